uart_rx_core: RTL

Synthesizable UART receiver that terminates the SoC's serial transmit line (`externalPins_uart_tx`) on the FPGA or bench side. It deserializes 8-bit frames into bytes and presents them on a valid/ready interface for a console logger or host bridge. It also feeds the board-level loopback path toward `externalPins_uart_rx`. Line format is fixed at 8 data bits, LSB first, optional parity, and 1 stop bit.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx_core.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_ODD  = 1;
  localparam int UART_PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRKWAIT
  } uart_rx_state_e;

  // One entry of the receive holding register.
  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
    logic                      frame_err;
    logic                      parity_err;
  } uart_rx_beat_t;

  function automatic logic parity_err_f(input int mode, input logic [UART_DATA_BITS-1:0] d,
                                        input logic pbit);
    logic x;
    x = ^{d, pbit};
    case (mode)
      UART_PAR_ODD:  parity_err_f = ~x;
      UART_PAR_EVEN: parity_err_f = x;
      default:       parity_err_f = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8-bit UART receiver (LSB first, optional parity, 1 stop bit) with a
// one-entry valid/ready holding register and overrun reporting.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rxd_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  uart_rx_state_e            state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      perr_q, perr_d;
  uart_rx_beat_t             hold_q, hold_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;
  logic                      frame_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // The detection cycle itself counts as tick 0 of the start bit.
        if (!rxd_s) begin
          state_d = ST_START;
          cnt_d   = CW'(1);
          bit_d   = '0;
          perr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT)
            state_d = (PARITY != UART_PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          perr_d  = parity_err_f(PARITY, shreg_q, rxd_s);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          frame_done = 1'b1;
          state_d    = rxd_s ? ST_IDLE : ST_BRKWAIT;
        end
      end
      ST_BRKWAIT: begin
        cnt_d = '0;
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A load wins over a same-cycle handshake clear; a full, stalled register drops the new byte.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (frame_done) begin
      if (!valid_q || rx_ready) begin
        valid_d           = 1'b1;
        hold_d.data       = shreg_q;
        hold_d.frame_err  = ~rxd_s;
        hold_d.parity_err = perr_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data       = hold_q.data;
  assign rx_frame_err  = hold_q.frame_err;
  assign rx_parity_err = hold_q.parity_err;
  assign rx_valid      = valid_q;
  assign rx_overrun    = ovr_q;

endmodule
